// File: rtl/clk_div_multi.sv
// -----------------------------------------------------------------------------
// clk_div_multi
//
// Multi-channel integer clock divider. Each channel derives a divided clock
// from i_ref_clk using its own ratio and enable. A new ratio is picked up only
// at a period boundary, so changing it never produces a runt pulse. The i_sync
// strobe restarts every enabled channel in phase.
//
// Parameters
//   CHANNELS     number of independent divider channels (1..8)
//   RATIO_W      width of each channel's division ratio
//
// Ports
//   i_ref_clk    reference clock; all logic runs on its rising edge
//   i_rst        synchronous, active-high reset
//   i_clk_en     per-channel enable
//   i_div_ratio  channel c ratio at bits [c*RATIO_W +: RATIO_W]
//   i_sync       one-cycle strobe that restarts all enabled channels
//   o_div_clk    divided clocks
//   o_div_pulse  period-start strobe, one per channel
//                (present only when CLK_DIV_PULSE_EN is defined)
//
// Optional feature macro: CLK_DIV_PULSE_EN
//
// Per-channel FSM
//   state     | meaning
//   ----------+----------------------------------------------------------
//   ST_IDLE   | channel disabled; output low, period counter held at 0
//   ST_DIVIDE | active ratio N >= 2; output high ceil(N/2), low floor(N/2)
//   ST_BYPASS | active ratio N <= 1; output follows i_ref_clk
//
// The enable register and bypass flag are carried in the state encoding:
// enabled means state != ST_IDLE, bypass means state == ST_BYPASS. Both only
// change at a load event or when the channel is disabled.
// -----------------------------------------------------------------------------
module clk_div_multi #(
  parameter int CHANNELS = 2,
  parameter int RATIO_W  = 8
) (
  input  logic                        i_ref_clk,
  input  logic                        i_rst,
  input  logic [CHANNELS-1:0]         i_clk_en,
  input  logic [CHANNELS*RATIO_W-1:0] i_div_ratio,
  input  logic                        i_sync,
  output logic [CHANNELS-1:0]         o_div_clk
`ifdef CLK_DIV_PULSE_EN
  ,
  output logic [CHANNELS-1:0]         o_div_pulse
`endif
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DIVIDE = 2'd1,
    ST_BYPASS = 2'd2
  } ch_state_e;

  localparam logic [RATIO_W-1:0] ONE = RATIO_W'(1);

  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch

    ch_state_e          state_q, state_d;
    logic [RATIO_W-1:0] n_q, n_d;
    logic [RATIO_W-1:0] k_q, k_d;
    logic               div_q, div_d;
    logic [RATIO_W-1:0] ratio;
    logic [RATIO_W-1:0] high_len;
    logic [RATIO_W-1:0] k_inc;
    logic               wrap;
    logic               load;

    assign ratio = i_div_ratio[c*RATIO_W +: RATIO_W];

    // High phase length ceil(N/2); written this way so N = 2^RATIO_W-1
    // cannot overflow.
    assign high_len = n_q - (n_q >> 1);

    // Inside ST_DIVIDE k never exceeds N-1, so the increment is only used
    // when it cannot overflow.
    assign k_inc = k_q + ONE;

    // A bypass period is a single reference cycle, so it ends every cycle.
    assign wrap = (state_q == ST_BYPASS) ||
                  ((state_q == ST_DIVIDE) && (k_q == n_q - ONE));

    // Load events: leaving idle, end of period, or sync. A simultaneous
    // disable suppresses the load.
    assign load = i_clk_en[c] && ((state_q == ST_IDLE) || wrap || i_sync);

    always_comb begin
      state_d = state_q;
      n_d     = n_q;
      k_d     = k_q;
      div_d   = div_q;

      if (!i_clk_en[c]) begin
        // Disable wins over sync and forces the output low right away,
        // even in the middle of the high phase.
        state_d = ST_IDLE;
        k_d     = '0;
        div_d   = 1'b0;
      end else if (load) begin
        n_d     = ratio;
        k_d     = '0;
        // k = 0 is always inside the high phase for N >= 2. In bypass the
        // registered level is masked by the output mux.
        div_d   = 1'b1;
        state_d = (ratio <= ONE) ? ST_BYPASS : ST_DIVIDE;
      end else begin
        k_d   = k_inc;
        div_d = (k_inc < high_len);
      end
    end

    always_ff @(posedge i_ref_clk) begin
      if (i_rst) begin
        state_q <= ST_IDLE;
        n_q     <= '0;
        k_q     <= '0;
        div_q   <= 1'b0;
      end else begin
        state_q <= state_d;
        n_q     <= n_d;
        k_q     <= k_d;
        div_q   <= div_d;
      end
    end

    // Final mux: the reference clock is passed through only while the
    // channel is enabled and the bypass flag is set.
    assign o_div_clk[c] = (state_q == ST_BYPASS) ? i_ref_clk : div_q;

`ifdef CLK_DIV_PULSE_EN
    logic pulse_q, pulse_d;

    // Registered alongside div_q, so the strobe lines up with the rising
    // divided clock. Bypass loads every cycle, which holds it at 1.
    assign pulse_d = load;

    always_ff @(posedge i_ref_clk) begin
      if (i_rst) begin
        pulse_q <= 1'b0;
      end else begin
        pulse_q <= pulse_d;
      end
    end

    assign o_div_pulse[c] = pulse_q;
`endif

  end : g_ch

endmodule : clk_div_multi

// File: tb/tb_clk_div_multi.sv
module tb_clk_div_multi;

  localparam int CHANNELS = 2;
  localparam int RATIO_W  = 8;

  logic                        clk;
  logic                        rst;
  logic [CHANNELS-1:0]         clk_en;
  logic [CHANNELS*RATIO_W-1:0] div_ratio;
  logic                        sync;
  logic [CHANNELS-1:0]         div_clk;
`ifdef CLK_DIV_PULSE_EN
  logic [CHANNELS-1:0]         div_pulse;
`endif

  int checks = 0;
  int errors = 0;

  logic [7:0]  pat_r4 = 8'b11001100;
  logic [13:0] pat_r8 = 14'b11110000101010;
  logic [5:0]  pat_r5 = 6'b111001;
  logic [5:0]  pul_r5 = 6'b100001;
  logic        e0, e1;

  clk_div_multi #(
    .CHANNELS (CHANNELS),
    .RATIO_W  (RATIO_W)
  ) dut (
    .i_ref_clk   (clk),
    .i_rst       (rst),
    .i_clk_en    (clk_en),
    .i_div_ratio (div_ratio),
    .i_sync      (sync),
    .o_div_clk   (div_clk)
`ifdef CLK_DIV_PULSE_EN
    ,
    .o_div_pulse (div_pulse)
`endif
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic half();
    @(negedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic set_ratio(input int ch, input int r);
    div_ratio[ch*RATIO_W +: RATIO_W] = RATIO_W'(r);
  endtask

  initial begin
    rst       = 1'b1;
    clk_en    = '0;
    div_ratio = '0;
    sync      = 1'b0;

    // Reset
    repeat (20) tick();
    chk("reset_ch0", div_clk[0], 1'b0);
    chk("reset_ch1", div_clk[1], 1'b0);
`ifdef CLK_DIV_PULSE_EN
    chk("reset_pulse0", div_pulse[0], 1'b0);
`endif

    // Enable ch0 at ratio 4: 2 high / 2 low, high right after enable edge
    rst = 1'b0;
    set_ratio(0, 4);
    clk_en = 2'b01;
    for (int i = 0; i < 8; i++) begin
      tick();
      chk("r4_ch0", div_clk[0], pat_r4[7-i]);
      chk("r4_ch1_idle", div_clk[1], 1'b0);
    end

    // ch0 ratio 3 picked up at the wrap, ch1 ratio 5 enabled a cycle later
    set_ratio(0, 3);
    set_ratio(1, 5);
    tick();
    chk("r3_first", div_clk[0], 1'b1);
    chk("r5_not_yet", div_clk[1], 1'b0);
    clk_en = 2'b11;
    for (int i = 0; i < 6; i++) begin
      if (i != 0) tick();
      else tick();
      e0 = (((i + 1) % 3) < 2);
      e1 = ((i % 5) < 3);
      chk("r3_pre_sync", div_clk[0], e0);
      chk("r5_pre_sync", div_clk[1], e1);
    end

    // Sync: both channels restart in phase and realign every 15 cycles
    sync = 1'b1;
    for (int j = 0; j < 30; j++) begin
      tick();
      sync = 1'b0;
      e0 = ((j % 3) < 2);
      e1 = ((j % 5) < 3);
      chk("r3_post_sync", div_clk[0], e0);
      chk("r5_post_sync", div_clk[1], e1);
    end

    // ch0 at ratio 8, switch to 2 while k=3: the 8-cycle period completes
    clk_en = 2'b01;
    set_ratio(0, 8);
    sync = 1'b1;
    for (int i = 0; i < 14; i++) begin
      tick();
      sync = 1'b0;
      chk("r8_to_r2", div_clk[0], pat_r8[13-i]);
      chk("r8_ch1_disabled", div_clk[1], 1'b0);
      if (i == 3) set_ratio(0, 2);
    end

    // Ratio 0: bypass begins only at the next boundary
    tick();
    chk("r2_k0", div_clk[0], 1'b1);
    set_ratio(0, 0);
    tick();
    chk("r0_pending_pos", div_clk[0], 1'b0);
    half();
    chk("r0_pending_neg", div_clk[0], 1'b0);
    for (int i = 0; i < 2; i++) begin
      tick();
      chk("r0_bypass_pos", div_clk[0], 1'b1);
`ifdef CLK_DIV_PULSE_EN
      chk("r0_bypass_pulse", div_pulse[0], 1'b1);
`endif
      half();
      chk("r0_bypass_neg", div_clk[0], 1'b0);
    end
    set_ratio(0, 1);
    tick();
    chk("r1_bypass_pos", div_clk[0], 1'b1);
    half();
    chk("r1_bypass_neg", div_clk[0], 1'b0);

    // Back to ratio 4: divided output resumes at the next (immediate) boundary
    set_ratio(0, 4);
    tick();
    chk("r4_resume_pos", div_clk[0], 1'b1);
    half();
    chk("r4_resume_neg", div_clk[0], 1'b1);
    for (int i = 1; i < 4; i++) begin
      tick();
      chk("r4_resume", div_clk[0], pat_r4[7-i]);
    end

    // Reset in the middle of the high phase
    tick();
    chk("pre_reset_high", div_clk[0], 1'b1);
    rst = 1'b1;
    tick();
    chk("mid_reset_ch0", div_clk[0], 1'b0);
    rst = 1'b0;
    tick();
    chk("post_reset_load", div_clk[0], 1'b1);
    tick();
    chk("post_reset_k1", div_clk[0], 1'b1);

    // Disable mid-high-phase forces low immediately
    clk_en = 2'b00;
    tick();
    chk("disable_low", div_clk[0], 1'b0);
    tick();
    chk("disable_hold", div_clk[0], 1'b0);

    // Re-enable with ratio 5: full period with the current ratio
    set_ratio(0, 5);
    clk_en = 2'b01;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("reenable_r5", div_clk[0], pat_r5[5-i]);
`ifdef CLK_DIV_PULSE_EN
      chk("pulse_r5", div_pulse[0], pul_r5[5-i]);
`endif
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_clk_div_multi
